// File: rtl/rrs_pkg.sv
// rrs_pkg: shared state, status and statistics definitions for read_request_sequencer
package rrs_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] RRS_OK      = 2'b00;
  localparam logic [1:0] RRS_MST_ERR = 2'b01;
  localparam logic [1:0] RRS_TIMEOUT = 2'b10;
  localparam int STAT_W = 16;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction
endpackage

// File: rtl/rrs_fifo.sv
// rrs_fifo: synchronous request queue with occupancy count; DEPTH must be a power of 2
module rrs_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] count_q;
  logic do_push, do_pop;
  assign full_o  = count_q == (PW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/read_request_sequencer.sv
// read_request_sequencer: queues slave read requests, issues them to the master, returns data with status.
// Optional saturating statistics counters are built when RRS_STATS_EN is defined.
module read_request_sequencer import rrs_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h40000000)
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          read_request,
  input  logic [ADDR_WIDTH-1:0]         read_address,
  output logic                          req_accepted,
  output logic                          req_dropped,
  output logic                          mst_read_request,
  output logic [ADDR_WIDTH-1:0]         mst_read_address,
  input  logic [DATA_WIDTH-1:0]         mst_value_read,
  input  logic                          mst_data_available,
  input  logic                          mst_error,
  output logic [DATA_WIDTH-1:0]         value_read,
  output logic                          data_available,
  output logic [1:0]                    rsp_status,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count,
  output logic [STAT_W-1:0]             stat_drops,
  output logic [STAT_W-1:0]             stat_timeouts,
  output logic [STAT_W-1:0]             stat_late
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic acc_q, acc_d, drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] wdata_q, addr_q, addr_d, head;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [1:0] st_q, st_d;
  logic [TW-1:0] to_q, to_d;
  logic full, empty, pop, timeout;
  logic [CW-1:0] count;
  rrs_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(S_AXI_ACLK), .rst_ni(S_AXI_ARESETN), .push_i(acc_q), .pop_i(pop),
    .wdata_i(wdata_q), .rdata_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  // Accepted requests are written a cycle later, so a staged entry already occupies a slot.
  always_comb begin
    drop_d = read_request & ((read_address[1:0] != 2'b00) | full | (acc_q & (count == CW'(FIFO_DEPTH-1))));
    acc_d  = read_request & ~drop_d;
  end
  assign timeout = to_q == TW'(TIMEOUT_CYCLES-1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    val_d   = val_q;
    st_d    = st_q;
    to_d    = to_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        addr_d  = BASE_ADDR + head;
        state_d = ISSUE;
      end
      ISSUE: begin
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: if (mst_data_available) begin
        val_d   = mst_value_read;
        st_d    = mst_error ? RRS_MST_ERR : RRS_OK;
        state_d = RESP;
      end else if (timeout) begin
        val_d   = '0;
        st_d    = RRS_TIMEOUT;
        state_d = RESP;
      end else begin
        to_d = to_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      drop_q  <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      val_q   <= '0;
      st_q    <= RRS_OK;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      wdata_q <= read_address;
      addr_q  <= addr_d;
      val_q   <= val_d;
      st_q    <= st_d;
      to_q    <= to_d;
    end
  end
  assign req_accepted     = acc_q;
  assign req_dropped      = drop_q;
  assign mst_read_request = state_q == ISSUE;
  assign mst_read_address = addr_q;
  assign data_available   = state_q == RESP;
  assign value_read       = val_q;
  assign rsp_status       = st_q;
  assign busy             = (state_q != IDLE) | ~empty;
  assign pending_count    = count;
`ifdef RRS_STATS_EN
  logic [STAT_W-1:0] drops_q, tos_q, late_q;
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      drops_q <= '0;
      tos_q   <= '0;
      late_q  <= '0;
    end else begin
      drops_q <= sat_inc(drops_q, drop_q);
      tos_q   <= sat_inc(tos_q, (state_q == WAIT) & ~mst_data_available & timeout);
      late_q  <= sat_inc(late_q, (state_q != WAIT) & mst_data_available);
    end
  end
  assign stat_drops    = drops_q;
  assign stat_timeouts = tos_q;
  assign stat_late     = late_q;
`else
  assign stat_drops    = '0;
  assign stat_timeouts = '0;
  assign stat_late     = '0;
`endif
endmodule

// File: tb/tb_read_request_sequencer.sv
// tb_read_request_sequencer: directed checks of queuing, issue latency, timeout, error status and reset
module tb_read_request_sequencer;
`ifdef RRS_STATS_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic rreq = 1'b0, mda = 1'b0, merr = 1'b0;
  logic [31:0] raddr = '0, mvr = '0;
  logic acc, drop, mrr, da, bsy;
  logic [31:0] maddr, vr;
  logic [1:0] st;
  logic [2:0] pc;
  logic [15:0] s_drops, s_tos, s_late;
  int n_cmp = 0, n_bad = 0;
  int acc_cnt = 0, drop_cnt = 0, mrr_cnt = 0, da_cnt = 0, pc_max = 0;
  always #5 clk = ~clk;
  read_request_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .read_request(rreq), .read_address(raddr),
    .req_accepted(acc), .req_dropped(drop), .mst_read_request(mrr), .mst_read_address(maddr),
    .mst_value_read(mvr), .mst_data_available(mda), .mst_error(merr), .value_read(vr),
    .data_available(da), .rsp_status(st), .busy(bsy), .pending_count(pc),
    .stat_drops(s_drops), .stat_timeouts(s_tos), .stat_late(s_late)
  );
  always @(negedge clk) begin
    if (acc) acc_cnt++;
    if (drop) drop_cnt++;
    if (mrr) mrr_cnt++;
    if (da) da_cnt++;
    if (int'(pc) > pc_max) pc_max = int'(pc);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_issue(input logic [31:0] addr);
    int n = 0;
    while (!mrr && n < 40) begin
      tick();
      n++;
    end
    check("issue_seen", mrr, 1);
    check("issue_addr", maddr, addr);
  endtask
  task automatic respond(input logic [31:0] data, input logic err, input int dly, input logic [1:0] exp_st);
    repeat (dly) tick();
    mda = 1'b1;
    mvr = data;
    merr = err;
    tick();
    mda = 1'b0;
    merr = 1'b0;
    check("rsp_pulse", da, 1);
    check("rsp_data", vr, data);
    check("rsp_status", st, exp_st);
  endtask
  initial begin
    int n, m0, d0;
    repeat (3) tick();
    check("rst_mrr", mrr, 0);
    check("rst_da", da, 0);
    check("rst_busy", bsy, 0);
    check("rst_pend", pc, 0);
    check("rst_status", st, 0);
    rstn = 1'b1;
    repeat (2) tick();
    // single read: request at cycle t, issue at t+3, response one cycle after the master's
    rreq = 1'b1; raddr = 32'h10;
    tick();
    rreq = 1'b0;
    check("t1_acc", acc, 1);
    check("t1_mrr_early", mrr, 0);
    tick();
    check("t1_pend", pc, 1);
    check("t1_busy", bsy, 1);
    check("t1_mrr_early2", mrr, 0);
    tick();
    check("t1_mrr", mrr, 1);
    check("t1_addr", maddr, 32'h40000010);
    repeat (3) tick();
    check("t1_no_da", da, 0);
    respond(32'hDEADBEEF, 1'b0, 1, 2'b00);
    tick();
    check("t1_da_once", da, 0);
    check("t1_idle", bsy, 0);
    // fill the queue while the master sits on the first request
    rreq = 1'b1; raddr = 32'h20;
    tick();
    rreq = 1'b0;
    wait_issue(32'h40000020);
    acc_cnt = 0; drop_cnt = 0; pc_max = 0;
    for (int i = 0; i < 5; i++) begin
      rreq = 1'b1;
      raddr = 32'h100 + 32'(4 * i);
      tick();
    end
    rreq = 1'b0;
    repeat (2) tick();
    check("t2_pend_full", pc, 4);
    check("t2_acc_cnt", acc_cnt, 4);
    check("t2_drop_cnt", drop_cnt, 1);
    check("t2_pc_max", pc_max, 4);
    respond(32'hA0A0A0A0, 1'b0, 0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wait_issue(32'h40000100 + 32'(4 * i));
      respond(32'hB0000000 + 32'(i), 1'b0, 2, 2'b00);
    end
    check("t2_stat_drops", s_drops, SE);
    // address wrap
    rreq = 1'b1; raddr = 32'hC0000004;
    tick();
    rreq = 1'b0;
    wait_issue(32'h00000004);
    respond(32'h55AA55AA, 1'b0, 1, 2'b00);
    // misaligned offset
    repeat (2) tick();
    m0 = mrr_cnt;
    rreq = 1'b1; raddr = 32'h6;
    tick();
    rreq = 1'b0;
    check("t3_drop", drop, 1);
    check("t3_acc", acc, 0);
    repeat (5) tick();
    check("t3_no_issue", mrr_cnt, m0);
    check("t3_pend", pc, 0);
    check("t3_stat_drops", s_drops, 2 * SE);
    // master error, and responses coinciding with the last timeout cycle
    rreq = 1'b1; raddr = 32'h30;
    tick();
    rreq = 1'b0;
    wait_issue(32'h40000030);
    respond(32'h12345678, 1'b1, 3, 2'b01);
    rreq = 1'b1; raddr = 32'h34;
    tick();
    rreq = 1'b0;
    wait_issue(32'h40000034);
    respond(32'h12345678, 1'b1, 16, 2'b01);
    rreq = 1'b1; raddr = 32'h38;
    tick();
    rreq = 1'b0;
    wait_issue(32'h40000038);
    respond(32'h87654321, 1'b0, 16, 2'b00);
    check("t5_no_timeouts", s_tos, 0);
    // silent master: timeout 16 cycles after WAIT entry, then a late response is ignored
    rreq = 1'b1; raddr = 32'h40;
    tick();
    rreq = 1'b0;
    wait_issue(32'h40000040);
    n = 0;
    while (!da && n < 40) begin
      tick();
      n++;
    end
    check("t4_to_latency", n, 17);
    check("t4_to_data", vr, 0);
    check("t4_to_status", st, 2'b10);
    d0 = da_cnt;
    tick();
    mda = 1'b1; mvr = 32'hFFFF0000;
    tick();
    mda = 1'b0;
    repeat (4) tick();
    check("t4_late_ignored", da_cnt, d0 + 1);
    check("t4_vr_held", vr, 0);
    check("t4_stat_late", s_late, SE);
    check("t4_stat_to", s_tos, SE);
    // reset during WAIT with two entries still queued
    for (int i = 0; i < 3; i++) begin
      rreq = 1'b1;
      raddr = 32'h200 + 32'(4 * i);
      tick();
    end
    rreq = 1'b0;
    wait_issue(32'h40000200);
    tick();
    check("t6_pend_pre", pc, 2);
    rstn = 1'b0;
    tick();
    check("t6_addr", maddr, 0);
    check("t6_da", da, 0);
    check("t6_status", st, 0);
    check("t6_busy", bsy, 0);
    check("t6_pend", pc, 0);
    check("t6_stat_drops", s_drops, 0);
    check("t6_stat_late", s_late, 0);
    rstn = 1'b1;
    d0 = da_cnt; m0 = mrr_cnt;
    mda = 1'b1; mvr = 32'h13572468;
    tick();
    mda = 1'b0;
    repeat (5) tick();
    check("t6_no_rsp", da_cnt, d0);
    check("t6_no_issue", mrr_cnt, m0);
    check("t6_vr", vr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/read_request_sequencer.md
Name: read_request_sequencer

Overview:
- Sits between AXI_slave and AXI_master in the AXI_master_and_slave top.
- Queues read_request/read_address pulses from the slave register file, offsets them by a base address, and issues them one at a time to the master.
- Collects value_read/data_available from the master, applies a timeout, and returns the result with a status code to the slave.
- Replaces the constant tie-offs on the slave's value_read/data_available inputs.

Parameters:
- ADDR_WIDTH, 32, width of request and master addresses.
- DATA_WIDTH, 32, width of read data.
- FIFO_DEPTH, 4, request queue entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, WAIT cycles before a timeout response; minimum 2.
- BASE_ADDR, 32'h40000000, added to every request offset.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  synchronous active-low reset.
- read_request  in  1  one-cycle request pulse from the slave.
- read_address  in  ADDR_WIDTH  byte offset; valid when read_request=1.
- req_accepted  out  1  pulse: request queued.
- req_dropped  out  1  pulse: request rejected (FIFO full or misaligned).
- mst_read_request  out  1  one-cycle pulse to the master.
- mst_read_address  out  ADDR_WIDTH  address to the master; held from issue until response.
- mst_value_read  in  DATA_WIDTH  read data from the master.
- mst_data_available  in  1  one-cycle pulse from the master; data valid.
- mst_error  in  1  qualifies mst_data_available; master saw SLVERR/DECERR.
- value_read  out  DATA_WIDTH  last response data; held until the next response.
- data_available  out  1  one-cycle response pulse to the slave.
- rsp_status  out  2  00 OK, 01 master error, 10 timeout; held with value_read.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- pending_count  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries.
- stat_drops, stat_timeouts, stat_late  out  16 each  statistics; see Optional Feature.

Behaviour:
- Reset (S_AXI_ARESETN=0 sampled at a rising edge):
  - FIFO emptied; FSM to IDLE; timeout counter cleared.
  - All outputs 0, including value_read, rsp_status and the stat counters.
  - Reset mid-transaction abandons that transaction; no response is produced for it.
- Accept, evaluated in the cycle read_request=1:
  - If read_address[1:0]!=0, or the FIFO is full at the start of the cycle, pulse req_dropped next cycle; nothing is written.
  - Full is decided before any same-cycle pop: a push into a full FIFO drops even if a pop occurs that cycle.
  - Otherwise write the entry and pulse req_accepted next cycle.
- Address arithmetic: mst_read_address = BASE_ADDR + offset, modulo 2^ADDR_WIDTH; wrap is silent.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: FIFO non-empty -> pop head into the address register, go to ISSUE.
  - ISSUE: mst_read_request=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT, mst_data_available=1: capture data, status = mst_error ? 01 : 00; go to RESP.
  - WAIT, counter reaches TIMEOUT_CYCLES-1 without a response: value_read = 0, status = 10; go to RESP.
  - WAIT, response and timeout in the same cycle: the response wins.
  - RESP: data_available=1 for one cycle, value_read/rsp_status updated in the same cycle; go to IDLE.
- Latency, idle with empty FIFO:
  - read_request in cycle N -> mst_read_request in cycle N+3.
  - mst_data_available in cycle M -> data_available in cycle M+1.
  - Back-to-back queued requests are issued every 3+k cycles, where k is the master response time.
- mst_data_available outside WAIT is a late or stray response: ignored, and counts as late.
- pending_count updates on the edge after each push or pop.
- busy is derived combinationally from registered state.

Optional Feature:
- Macro: RRS_STATS_EN.
- Defined:
  - stat_drops, stat_timeouts and stat_late are 16-bit saturating counters, holding at 16'hFFFF.
  - Each increments once per req_dropped, timeout response, or ignored mst_data_available respectively.
  - All three are cleared only by reset.
- Undefined: the counters are not built; the ports remain and are driven constant 0.

Decomposition:
- Package rrs_pkg:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - Status codes RRS_OK=2'b00, RRS_MST_ERR=2'b01, RRS_TIMEOUT=2'b10.
  - Stat counter width 16.
- Sub-module rrs_fifo: synchronous FIFO, ADDR_WIDTH wide and FIFO_DEPTH deep, with push, pop, full, empty and count.

Test Plan:
- Single read, offset 0x10 at cycle 5, master responds 4 cycles after issue with 0xDEADBEEF, mst_error=0 -> mst_read_address=0x40000010, mst_read_request in cycle 8, data_available once with value_read=0xDEADBEEF and rsp_status=00.
- Five back-to-back requests with FIFO_DEPTH=4 and the master stalled -> four req_accepted and one req_dropped, pending_count tops out at 4, then four in-order responses; stat_drops=1 with RRS_STATS_EN.
- Misaligned offset 0x6 -> req_dropped, no mst_read_request, pending_count unchanged.
- Master silent with TIMEOUT_CYCLES=16 -> data_available 16 cycles after WAIT entry with value_read=0 and rsp_status=10; a later mst_data_available is ignored and stat_late=1.
- mst_error=1 response with data 0x12345678 -> rsp_status=01, value_read=0x12345678; response coincident with the timeout edge -> status 00/01, not 10.
- Reset asserted one cycle into WAIT with 2 entries queued -> all outputs 0 next cycle, no data_available, pending_count=0; a subsequent stray mst_data_available produces no response.
